// File: rtl/alert_pkg.sv
// Shared types and constants for the multi-channel alert pattern generator.
package alert_pkg;

    localparam logic [1:0] ENC_OFF   = 2'b00;
    localparam logic [1:0] ENC_SOLID = 2'b01;
    localparam logic [1:0] ENC_BLINK = 2'b10;
    localparam logic [1:0] ENC_BURST = 2'b11;

    typedef enum logic [1:0] {
        MODE_OFF   = ENC_OFF,
        MODE_SOLID = ENC_SOLID,
        MODE_BLINK = ENC_BLINK,
        MODE_BURST = ENC_BURST
    } alert_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } alert_state_t;

    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/alert_pattern_gen_if.sv
// Status-side bundle: global enable, packed per-channel modes, channel drives.
interface alert_pattern_gen_if #(
    parameter int NUM_CH = 4
);
    logic                  sys_active;
    logic [2*NUM_CH-1:0]   mode;
    logic [NUM_CH-1:0]     ledSpkr;

    modport master (
        output sys_active,
        output mode,
        input  ledSpkr
    );

    modport slave (
        input  sys_active,
        input  mode,
        output ledSpkr
    );
endinterface

// File: rtl/alert_channel.sv
// One alert channel: pattern FSM, phase/pulse counters and registered mode.
module alert_channel
    import alert_pkg::*;
#(
    parameter int BLINK_CYC = 10_000_000,
    parameter int PULSE_CYC = 2_500_000,
    parameter int GAP_CYC   = 20_000_000,
    parameter int BURST_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active_i,
    input  alert_mode_t mode_i,
    output logic        led_o
);

    localparam int CW = cnt_width(BLINK_CYC, PULSE_CYC, GAP_CYC);
    localparam int PW = $clog2(BURST_LEN + 1);

    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PULSE_FIN  = PW'(BURST_LEN - 1);

    alert_state_t  state_q, state_d;
    alert_mode_t   mode_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_i;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            led_q   <= (state_d == ST_ON);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        // Deactivation or a mode change parks the channel for one cycle.
        if (!active_i || (mode_i != mode_q)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_q != MODE_OFF) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        pcnt_d  = '0;
                    end
                end
                ST_ON: begin
                    unique case (mode_q)
                        MODE_SOLID: cnt_d = '0;
                        MODE_BLINK: begin
                            if (cnt_q == BLINK_LAST) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        MODE_BURST: begin
                            if (cnt_q == PULSE_LAST) begin
                                cnt_d = '0;
                                if (pcnt_q == PULSE_FIN) begin
                                    state_d = ST_GAP;
                                end else begin
                                    state_d = ST_OFF;
                                    pcnt_d  = pcnt_q + 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            pcnt_d  = '0;
                        end
                    endcase
                end
                ST_OFF: begin
                    if ((mode_q == MODE_BLINK && cnt_q == BLINK_LAST) ||
                        (mode_q == MODE_BURST && cnt_q == PULSE_LAST)) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else if (mode_q == MODE_BLINK ||
                                 mode_q == MODE_BURST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        pcnt_d  = '0;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        pcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/alert_pattern_gen.sv
// Multi-channel LED/speaker alert generator top.
// Define ALERT_SYNC_EN to pass sys_active through a 2-flop synchronizer.
module alert_pattern_gen
    import alert_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BLINK_CYC = 10_000_000,
    parameter int PULSE_CYC = 2_500_000,
    parameter int GAP_CYC   = 20_000_000,
    parameter int BURST_LEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alert_pattern_gen_if.slave bus
);

    logic              active;
    logic [NUM_CH-1:0] led;

`ifdef ALERT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], bus.sys_active};
    end

    assign active = sync_q[1];
`else
    assign active = bus.sys_active;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        alert_channel #(
            .BLINK_CYC (BLINK_CYC),
            .PULSE_CYC (PULSE_CYC),
            .GAP_CYC   (GAP_CYC),
            .BURST_LEN (BURST_LEN)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .active_i (active),
            .mode_i   (alert_mode_t'(bus.mode[2*i +: 2])),
            .led_o    (led[i])
        );
    end

    assign bus.ledSpkr = led;

endmodule

// File: tb/tb_alert_pattern_gen.sv
// Directed bench for alert_pattern_gen: 2 channels, short phase lengths.
module tb_alert_pattern_gen;

    localparam int NUM_CH    = 2;
    localparam int BLINK_CYC = 4;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 6;
    localparam int BURST_LEN = 3;

`ifdef ALERT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    localparam logic [7:0]  P0 = 8'b1111_0000;
    localparam logic [15:0] P1 = 16'b1100_1100_1100_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alert_pattern_gen_if #(.NUM_CH(NUM_CH)) bus ();

    alert_pattern_gen #(
        .NUM_CH    (NUM_CH),
        .BLINK_CYC (BLINK_CYC),
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic p0(input int k);
        return P0[7 - (k % 8)];
    endfunction

    function automatic logic p1(input int k);
        return P1[15 - (k % 16)];
    endfunction

    task automatic cyc(input string tag, input logic e0, input logic e1);
        @(posedge clk);
        #1;
        chk(tag, 32'(bus.ledSpkr), 32'({e1, e0}));
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.sys_active = 1'b0;
        bus.mode       = 4'b1010;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'(bus.ledSpkr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (20) cyc("idle_inactive", 1'b0, 1'b0);

        bus.mode = 4'b1110;
        repeat (2) cyc("mode_load", 1'b0, 1'b0);

        bus.sys_active = 1'b1;
        repeat (SL) cyc("act_lat", 1'b0, 1'b0);
        for (int k = 0; k < 34; k++) cyc("pattern", p0(k), p1(k));

        bus.mode = 4'b1101;
        cyc("mode_chg_gap", 1'b0, p1(34));
        for (int k = 35; k < 53; k++) cyc("solid", 1'b1, p1(k));

        bus.sys_active = 1'b0;
        for (int k = 53; k < 53 + SL; k++) cyc("deact_lat", 1'b1, p1(k));
        repeat (5) cyc("inactive", 1'b0, 1'b0);

        bus.sys_active = 1'b1;
        repeat (SL) cyc("react_lat", 1'b0, 1'b0);
        for (int j = 0; j < 17; j++) cyc("restart", 1'b1, p1(j));

        #2 rst_n = 1'b0;
        #1 chk("rst_mid_on", 32'(bus.ledSpkr), 32'd0);
        repeat (3) cyc("rst_hold", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alert_pattern_gen.md
# alert_pattern_gen

Parametrised multi-channel LED/speaker alert generator, successor to the single-channel fixed-rate blinker. Each channel independently drives one output with a selectable pattern: off, solid, symmetric blink, or multi-pulse burst followed by a gap. All channels share a global `sys_active` enable. The block sits between the system-status logic and the board LED/speaker pins.

## Interface
- `NUM_CH`, 4: number of independent output channels.
- `BLINK_CYC`, 10_000_000: length of each BLINK half-period, in clk cycles (≥1).
- `PULSE_CYC`, 2_500_000: length of each BURST on-pulse and inter-pulse off time, in cycles (≥1).
- `GAP_CYC`, 20_000_000: length of the BURST post-burst gap, in cycles (≥1).
- `BURST_LEN`, 3: on-pulses per burst (≥1).
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sys_active`  in  1  global enable; low forces every channel idle.
- `mode`  in  2*NUM_CH  per-channel mode; channel i uses bits [2i+1:2i].
- `ledSpkr`  out  NUM_CH  per-channel drive; 1 = LED on / speaker on.

## Operation
- Mode encoding: 00 OFF, 01 SOLID, 10 BLINK, 11 BURST.
- Per-channel FSM with states IDLE, ON, OFF, GAP. It uses a cycle counter of width `$clog2(max(BLINK_CYC,PULSE_CYC,GAP_CYC))` and a pulse counter of width `$clog2(BURST_LEN+1)`.
- `ledSpkr[i]` is a flop. It is 1 only while channel i is in ON, and is updated on the same edge as the state.
- IDLE transitions:
  - Goes to ON when `sys_active`=1 and mode≠OFF.
  - Counters are cleared on entry to ON.
- ON transitions:
  - SOLID: stays in ON with the counter held at 0.
  - BLINK: goes to OFF after BLINK_CYC cycles.
  - BURST: after PULSE_CYC cycles, goes to GAP if this was pulse BURST_LEN; otherwise goes to OFF and increments the pulse count.
- OFF transitions:
  - BLINK: goes to ON after BLINK_CYC cycles.
  - BURST: goes to ON after PULSE_CYC cycles.
- GAP: goes to ON after GAP_CYC cycles, and the pulse count clears.
- Every phase lasts exactly its parameter in cycles, including the first ON phase after activation or restart.
- Mode change:
  - Each channel registers its mode in `mode_q`.
  - When `mode`≠`mode_q` on an edge, the channel goes to IDLE on that edge, clears its counters and updates `mode_q`.
  - Result: output low for exactly one cycle, then the new pattern starts from its ON phase. If the new mode is OFF, the channel stays IDLE.
- `sys_active` low: on the next edge, every channel goes to IDLE, every output goes to 0 and all counters clear. Re-raising the enable restarts all channels at pulse 1 / first ON phase.
- Channels are independent; no phase alignment exists between them.
- Reset (async, any time): all states IDLE, all counters 0, `mode_q`=OFF, `ledSpkr`=0 immediately without a clock edge.

## Timing
- Activation latency: `sys_active` sampled high on edge E → `ledSpkr` high after E (same edge).
- Deactivation latency: one edge.
- BLINK period: 2*BLINK_CYC.
- BURST period: (2*BURST_LEN−1)*PULSE_CYC + GAP_CYC. The last pulse is followed by GAP, not OFF.
- Simultaneous `sys_active` fall and mode change: deactivation wins; the channel goes to IDLE and `mode_q` still updates.
- Counter wrap is impossible: each counter clears on every phase transition.

## Configuration
- `ALERT_SYNC_EN` defined:
  - `sys_active` passes through a 2-flop synchronizer that resets to 0.
  - Activation and deactivation latency each grow by 2 cycles.
  - `mode` must still be synchronous to `clk`.
- Not defined: `sys_active` is used directly and must be synchronous to `clk`.

## Structure
- Package `alert_pkg`:
  - `alert_mode_t` (2-bit enum OFF/SOLID/BLINK/BURST).
  - `alert_state_t` (IDLE/ON/OFF/GAP).
  - Mode encoding constants.
- Sub-module `alert_channel`:
  - One FSM with its counters and `mode_q`.
  - Instantiated NUM_CH times via generate.
  - The top level holds the optional synchronizer and the port slicing.

## Test plan
Bench parameters: NUM_CH=2, BLINK_CYC=4, PULSE_CYC=2, GAP_CYC=6, BURST_LEN=3.
- Reset: `rst_n`=0 → `ledSpkr`=00. Release with `sys_active`=0 and both modes BLINK → `ledSpkr` stays 00 for 20 cycles.
- ch0 BLINK, `sys_active` rises → `ledSpkr[0]` follows 1111 0000 repeating (period 8, first ON is exactly 4 cycles).
- ch1 BURST → `ledSpkr[1]` follows 11 00 11 00 11 000000 repeating (period 16).
- ch0 BLINK→SOLID at cycle 2 of an ON phase → output 0 for exactly 1 cycle, then constant 1. ch1 is unaffected.
- `sys_active` drops during the second burst pulse → output 0 on the next edge. Re-raise after 5 cycles → the burst restarts with a full 2-cycle first pulse.
- `rst_n` asserted mid-ON → `ledSpkr`=00 asynchronously. With `ALERT_SYNC_EN`, activation output rises 2 cycles later than without.
